ifetch_stage: RTL and testbench

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_stage.sv | 120 ++++++++++++
 tb/tb_ifetch_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC register, single outstanding memory request,
// and a 2-entry {instr, pc} buffer feeding the decode stage.
module ifetch_stage #(
  parameter int unsigned    n        = 16,
  parameter logic [n-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [n-1:0] instr,
  output logic [n-1:0] instr_pc,
  output logic [3:0]   op
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [n-1:0] PC_STEP = n'(2);

  state_t       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] addr_q, addr_d;

  logic [n-1:0] buf_instr [2];
  logic [n-1:0] buf_pc    [2];
  logic         rptr_q, wptr_q;
  logic [1:0]   count_q, count_after;

  logic pop, push, issue;

  always_comb begin
    instr_valid = (count_q != 2'd0);
    pop         = instr_valid & instr_ready & ~redirect;
    push        = (state_q == WAIT) & imem_ack & ~redirect;
    count_after = count_q - {1'b0, pop} + {1'b0, push};
  end

  // A new request is only issued when the response is guaranteed a free slot.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect)                 pc_d  = redirect_pc;
        else if (count_after < 2'd2)  issue = 1'b1;
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          if (count_after < 2'd2) issue   = 1'b1;
          else                    state_d = IDLE;
        end
      end
      DROP: begin
        if (redirect) pc_d    = redirect_pc;
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d = WAIT;
      addr_d  = pc_q;
      pc_d    = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      count_q <= '0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      if (redirect) begin
        count_q <= '0;
        rptr_q  <= 1'b0;
        wptr_q  <= 1'b0;
      end else begin
        if (push) wptr_q <= ~wptr_q;
        if (pop)  rptr_q <= ~rptr_q;
        count_q <= count_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_instr[wptr_q] <= imem_rdata;
      buf_pc[wptr_q]    <= addr_q;
    end
  end

  always_comb begin
    imem_req  = (state_q != IDLE);
    imem_addr = addr_q;
    instr     = instr_valid ? buf_instr[rptr_q] : '0;
    instr_pc  = instr_valid ? buf_pc[rptr_q]    : '0;
    op        = instr[n-1:n-4];
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios plus randomized traffic, checked
// against a transaction-level model (expected fetch/delivery address streams).
module tb_ifetch_stage;

  localparam logic [15:0] RPC0 = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, redirect, instr_valid, instr_ready;
  logic [15:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic [3:0]  op;

  ifetch_stage #(.n(16), .RESET_PC(RPC0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .op(op)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // reference model state
  int          occ = 0;
  logic [15:0] exp_pop = RPC0, exp_fetch = RPC0;
  bit          stale = 0;
  bit          prev_req = 0, prev_ack = 0, prev_redir = 0, prev_reset = 1;
  logic [15:0] prev_addr = '0;

  // memory responder state
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  int          lat = 0;
  bit          force_ack = 0;

  bit          new_req;
  logic [15:0] last_new_addr = '0;
  int          new_req_count = 0;

  function automatic logic [15:0] memword(input logic [15:0] a);
    if (a == 16'hFFFE) return 16'h7123;
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: answer memory, check outputs, advance the model, cross the edge.
  task automatic tick(input bit redir_on_ack);
    logic [15:0] w;
    bit pop, push;
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hDEAD;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_cnt  = (lat < 0) ? $urandom_range(0, 3) : lat;
      end
      imem_ack   = (mem_cnt == 0);
      imem_rdata = imem_ack ? memword(imem_addr) : 16'($urandom);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
    if (redir_on_ack && imem_ack) redirect = 1'b1;
    #1;

    new_req = imem_req && (!prev_req || prev_ack);
    if (prev_reset) chk1("reset_req", imem_req, 1'b0);
    chk1("valid_vs_occ", instr_valid, occ != 0);
    if (instr_valid) begin
      w = memword(exp_pop);
      chk16("head_pc", instr_pc, exp_pop);
      chk16("head_instr", instr, w);
      chk16("head_op", {12'b0, op}, {12'b0, w[15:12]});
    end else begin
      chk16("empty_instr", instr, 16'h0000);
      chk16("empty_pc", instr_pc, 16'h0000);
      chk16("empty_op", {12'b0, op}, 16'h0000);
    end
    if (imem_req && prev_req && !prev_ack && !prev_reset)
      chk16("addr_stable", imem_addr, prev_addr);
    if (new_req) begin
      chk16("fetch_addr", imem_addr, exp_fetch);
      exp_fetch     = exp_fetch + 16'd2;
      last_new_addr = imem_addr;
      new_req_count++;
    end
    if (prev_redir) chk1("redir_no_early_req", new_req, 1'b0);

    if (reset) begin
      occ = 0; exp_pop = RPC0; exp_fetch = RPC0; stale = 0; mem_busy = 0;
    end else begin
      pop  = (occ != 0) && instr_ready && !redirect;
      push = imem_req && imem_ack && !stale && !redirect;
      if (pop) exp_pop = exp_pop + 16'd2;
      if (redirect) begin
        occ = 0; exp_pop = redirect_pc; exp_fetch = redirect_pc;
      end else begin
        occ = occ + int'(push) - int'(pop);
      end
      if (imem_req && imem_ack) stale = 0;
      if (redirect && imem_req && !imem_ack) stale = 1;
      if (imem_ack) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
    end
    prev_req   = imem_req;
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
    prev_redir = redirect && !reset;
    prev_reset = reset;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(0);
    tick(0);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    bit did;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // back-to-back fetch at zero latency
    lat = 0; instr_ready = 1'b1;
    do_reset();
    chk1("rst_valid", instr_valid, 1'b0);
    chk16("rst_op", {12'b0, op}, 16'h0000);
    tick(0);
    for (int k = 0; k < 8; k++) begin
      chk1("stream_req", imem_req, 1'b1);
      chk16("stream_addr", imem_addr, 16'(2 * k));
      if (k > 0) chk16("stream_pc", instr_pc, 16'(2 * (k - 1)));
      tick(0);
    end

    // decode stall fills the buffer and stops fetching
    instr_ready = 1'b0;
    do_reset();
    repeat (5) tick(0);
    chk1("stall_valid", instr_valid, 1'b1);
    chk1("stall_req", imem_req, 1'b0);
    chk16("stall_head", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    tick(0);
    chk16("drain_head", instr_pc, 16'h0002);
    chk1("resume_req", imem_req, 1'b1);
    chk16("resume_addr", imem_addr, 16'h0004);

    // redirect while a slow response is outstanding
    lat = 3; instr_ready = 1'b1;
    do_reset();
    tick(0);
    tick(0);
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick(0);
    redirect = 1'b0;
    base = new_req_count;
    for (int i = 0; i < 12 && new_req_count == base; i++) tick(0);
    chk1("drop_req_seen", new_req_count != base, 1'b1);
    chk16("drop_new_addr", last_new_addr, 16'h0100);
    for (int i = 0; i < 12 && !instr_valid; i++) tick(0);
    chk1("drop_valid", instr_valid, 1'b1);
    chk16("drop_first_pc", instr_pc, 16'h0100);

    // redirect coinciding with ack while one entry is buffered
    lat = 1; instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !instr_valid; i++) tick(0);
    chk1("coinc_pre_valid", instr_valid, 1'b1);
    redirect_pc = 16'h0200;
    did = 0;
    for (int i = 0; i < 6 && !did; i++) begin
      tick(1);
      did = redirect;
      redirect = 1'b0;
    end
    chk1("coinc_hit", did, 1'b1);
    chk1("coinc_flushed", instr_valid, 1'b0);
    base = new_req_count;
    for (int i = 0; i < 12 && new_req_count == base; i++) tick(0);
    chk16("coinc_new_addr", last_new_addr, 16'h0200);

    // PC wrap and opcode passthrough
    lat = 4; instr_ready = 1'b0;
    do_reset();
    base = new_req_count;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick(0);
    redirect = 1'b0;
    for (int i = 0; i < 30 && !instr_valid; i++) tick(0);
    chk16("wrap_instr", instr, 16'h7123);
    chk16("wrap_op", {12'b0, op}, 16'h0007);
    chk16("wrap_pc", instr_pc, 16'hFFFE);
    for (int i = 0; i < 30 && new_req_count < base + 2; i++) tick(0);
    chk16("wrap_next_addr", last_new_addr, 16'h0000);
    instr_ready = 1'b1;
    tick(0);
    instr_ready = 1'b0;
    chk1("wrap_empty_valid", instr_valid, 1'b0);
    chk16("wrap_empty_op", {12'b0, op}, 16'h0000);

    // reset abandons a pending request; a stray ack afterwards is ignored
    lat = 3; instr_ready = 1'b1;
    do_reset();
    tick(0);
    tick(0);
    do_reset();
    force_ack = 1'b1;
    tick(0);
    force_ack = 1'b0;
    chk1("stray_ack_valid", instr_valid, 1'b0);
    chk1("stray_ack_req", imem_req, 1'b1);
    chk16("stray_ack_addr", imem_addr, RPC0);
    repeat (8) tick(0);

    // randomized traffic
    lat = -1;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      reset       = ($urandom_range(0, 199) == 0);
      tick(0);
    end
    reset = 1'b0; redirect = 1'b0;
    repeat (4) tick(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
